// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: shared state encoding and default sizing for the serial pattern transmitter
package pattern_tx_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP = 1;
  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, GAP, DONE} state_t;
endpackage

// File: rtl/pattern_tx_if.sv
// pattern_tx_if: request handshake plus serial output bundle of pattern_tx
// master drives in_valid/in_data/in_len/in_reps; slave drives in_ready/x/x_valid/done
interface pattern_tx_if
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = $clog2(WIDTH) + 1,
  parameter int CNT_W = DEF_CNT_W
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic [CNT_W-1:0] in_reps;
  logic x;
  logic x_valid;
  logic done;
  modport master (output in_valid, in_data, in_len, in_reps, input in_ready, x, x_valid, done);
  modport slave (input in_valid, in_data, in_len, in_reps, output in_ready, x, x_valid, done);
endinterface

// File: rtl/pattern_tx_cnt.sv
// pattern_tx_cnt: loadable down-counter that saturates at zero and flags the terminal value
// ports: clk, rst_n (sync active-low), load/val reload, dec step, q count, tc (q == 0)
module pattern_tx_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic [W-1:0] q,
  output logic         tc
);
  always_ff @(posedge clk)
    q <= !rst_n ? '0 : load ? val : (dec && !tc) ? q - 1'b1 : q;
  assign tc = q == '0;
endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: bit-serial pattern transmitter, MSB-first frames repeated with idle gaps
// ports: clk, rst_n (sync active-low), bus (pattern_tx_if.slave: in_valid/in_ready/in_data/
//   in_len/in_reps request, x/x_valid serial output, done completion pulse)
// PATTERN_TX_PARITY_EN appends an even-parity bit after every frame
module pattern_tx #(
  parameter int WIDTH = pattern_tx_pkg::DEF_WIDTH,
  parameter int LEN_W = $clog2(WIDTH) + 1,
  parameter int CNT_W = pattern_tx_pkg::DEF_CNT_W,
  parameter int GAP = pattern_tx_pkg::DEF_GAP
) (
  input logic clk,
  input logic rst_n,
  pattern_tx_if.slave bus
);
  import pattern_tx_pkg::*;
  localparam int GAP_W = $clog2(GAP + 2);
  state_t state_q, state_d;
  logic [WIDTH-1:0] dat_q, sh;
  logic [LEN_W-1:0] len_q, len_c, bit_q, nidx;
  logic [CNT_W-1:0] frm_unused;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic acc, start, fend, degen, bit_dec, frm_dec, bit_tc, frm_tc, x_d, xv_d;
  assign len_c = (bus.in_len > LEN_W'(WIDTH)) ? '0 : bus.in_len;
  assign degen = len_c == '0 || bus.in_reps == '0;
`ifdef PATTERN_TX_PARITY_EN
  logic par_q;
  assign fend = state_q == PARITY;
`else
  assign fend = state_q == SHIFT && bit_tc;
`endif
  always_comb begin
    state_d = state_q;
    acc = 1'b0;
    start = 1'b0;
    bit_dec = 1'b0;
    frm_dec = 1'b0;
    gap_d = gap_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        acc = 1'b1;
        start = !degen;
        state_d = degen ? DONE : SHIFT;
      end
      SHIFT: begin
        bit_dec = !bit_tc;
`ifdef PATTERN_TX_PARITY_EN
        if (bit_tc) state_d = PARITY;
`endif
      end
`ifdef PATTERN_TX_PARITY_EN
      PARITY: state_d = PARITY;
`endif
      pattern_tx_pkg::GAP: if (gap_q == '0) begin
        start = 1'b1;
        state_d = SHIFT;
      end else gap_d = gap_q - 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // frame boundary: finish, idle gap, or reload the bit index for a back-to-back frame
    if (fend) begin
      if (frm_tc) state_d = DONE;
      else begin
        frm_dec = 1'b1;
        if (GAP > 0) begin
          state_d = pattern_tx_pkg::GAP;
          gap_d = GAP_W'(GAP - 1);
        end else begin
          start = 1'b1;
          state_d = SHIFT;
        end
      end
    end
    nidx = (start ? (acc ? len_c : len_q) : bit_q) - 1'b1;
    sh = (acc ? bus.in_data : dat_q) >> nidx;
`ifdef PATTERN_TX_PARITY_EN
    x_d = state_d == SHIFT ? sh[0] : state_d == PARITY && par_q;
    xv_d = state_d == SHIFT || state_d == PARITY;
`else
    x_d = state_d == SHIFT && sh[0];
    xv_d = state_d == SHIFT;
`endif
  end
  pattern_tx_cnt #(.W(LEN_W)) u_bit (
    .clk(clk), .rst_n(rst_n), .load(start), .dec(bit_dec), .val(nidx), .q(bit_q), .tc(bit_tc)
  );
  pattern_tx_cnt #(.W(CNT_W)) u_frm (
    .clk(clk), .rst_n(rst_n), .load(acc), .dec(frm_dec), .val(bus.in_reps - 1'b1),
    .q(frm_unused), .tc(frm_tc)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gap_q <= '0;
      bus.x <= 1'b0;
      bus.x_valid <= 1'b0;
      bus.done <= 1'b0;
      bus.in_ready <= 1'b1;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      bus.x <= x_d;
      bus.x_valid <= xv_d;
      bus.done <= state_d == DONE;
      bus.in_ready <= state_d == IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      dat_q <= bus.in_data;
      len_q <= len_c;
`ifdef PATTERN_TX_PARITY_EN
      par_q <= ^(bus.in_data & ~({WIDTH{1'b1}} << len_c));
`endif
    end
  end
endmodule
